// File: rtl/hazard_ctrl.sv
// Five-stage RV32I hazard controller: stall/flush generation, E-stage forwarding and memory-wait timeout.
// Optional performance counters are built when HAZARD_PERF_CNT_EN is defined.
module hazard_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int WCNT_W      = $clog2(MEM_TIMEOUT + 1)
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [4:0]  Rs1_d,
  input  logic [4:0]  Rs2_d,
  input  logic [4:0]  Rs1_e,
  input  logic [4:0]  Rs2_e,
  input  logic [4:0]  Rd_e,
  input  logic [4:0]  Rd_m,
  input  logic [4:0]  Rd_w,
  input  logic        Reg_write_m,
  input  logic        Reg_write_w,
  input  logic        Load_e,
  input  logic        Pc_src_e,
  input  logic        Mem_req_m,
  input  logic        Mem_ready,
  output logic        Stall_f,
  output logic        Stall_d,
  output logic        Stall_e,
  output logic        Stall_m,
  output logic        Flush_d,
  output logic        Flush_e,
  output logic        Flush_w,
  output logic [1:0]  Forward_a_e,
  output logic [1:0]  Forward_b_e,
  output logic        Mem_err,
  output logic [31:0] Stall_cycles,
  output logic [31:0] Flush_events
);

  typedef enum logic [1:0] {RUN, MWAIT, ERR} state_e;

  localparam logic [WCNT_W-1:0] TimeoutLast = WCNT_W'(MEM_TIMEOUT - 1);

  state_e            state_q;
  logic [WCNT_W-1:0] wait_cnt_q;
  logic              mem_err_q;

  logic mem_stall;
  logic lw_stall;
  logic frozen;
  logic branch_flush;

  assign mem_stall = Mem_req_m && !Mem_ready;
  assign lw_stall  = Load_e && (Rd_e != 5'd0) && ((Rd_e == Rs1_d) || (Rd_e == Rs2_d));
  assign frozen    = (state_q == ERR) || mem_stall;

  // M-stage result is newer than W, so it wins when both match the source.
  function automatic logic [1:0] fwd_sel(input logic [4:0] rs);
    if (Reg_write_m && (Rd_m != 5'd0) && (Rd_m == rs)) return 2'b10;
    else if (Reg_write_w && (Rd_w != 5'd0) && (Rd_w == rs)) return 2'b01;
    else return 2'b00;
  endfunction

  always_comb begin
    Stall_f      = 1'b0;
    Stall_d      = 1'b0;
    Stall_e      = 1'b0;
    Stall_m      = 1'b0;
    Flush_d      = 1'b0;
    Flush_e      = 1'b0;
    Flush_w      = 1'b0;
    Forward_a_e  = 2'b00;
    Forward_b_e  = 2'b00;
    branch_flush = 1'b0;
    if (Reset) begin
      Flush_d = 1'b1;
      Flush_e = 1'b1;
      Flush_w = 1'b1;
    end else begin
      Forward_a_e = fwd_sel(Rs1_e);
      Forward_b_e = fwd_sel(Rs2_e);
      if (frozen) begin
        Stall_f = 1'b1;
        Stall_d = 1'b1;
        Stall_e = 1'b1;
        Stall_m = 1'b1;
        Flush_w = 1'b1;
      end else if (Pc_src_e) begin
        Flush_d      = 1'b1;
        Flush_e      = 1'b1;
        branch_flush = 1'b1;
      end else if (lw_stall) begin
        Stall_f = 1'b1;
        Stall_d = 1'b1;
        Flush_e = 1'b1;
      end
    end
  end

  // Wait counter tracks consecutive unready cycles; reaching the limit latches ERR until reset.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q    <= RUN;
      wait_cnt_q <= '0;
      mem_err_q  <= 1'b0;
    end else begin
      case (state_q)
        RUN, MWAIT: begin
          if (mem_stall) begin
            wait_cnt_q <= wait_cnt_q + 1'b1;
            if (wait_cnt_q == TimeoutLast) begin
              state_q   <= ERR;
              mem_err_q <= 1'b1;
            end else begin
              state_q <= MWAIT;
            end
          end else begin
            state_q    <= RUN;
            wait_cnt_q <= '0;
          end
        end
        default: begin
          state_q   <= ERR;
          mem_err_q <= 1'b1;
        end
      endcase
    end
  end

  assign Mem_err = mem_err_q;

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (Stall_f) stall_cnt_d = stall_cnt_q + 32'd1;
    if (branch_flush) flush_cnt_d = flush_cnt_q + 32'd1;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign Stall_cycles = stall_cnt_q;
  assign Flush_events = flush_cnt_q;
`else
  assign Stall_cycles = 32'd0;
  assign Flush_events = 32'd0;
`endif

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller for the five-stage RV32I core. It generates the Stall/Clear controls for the F/D, D/E, E/M and M/W pipeline registers and the E-stage operand-forwarding selects. It resolves three kinds of hazard: load-use, taken branch/jump, and multi-cycle data-memory wait. A wait-cycle counter escalates an unanswered memory request to a sticky error.

## Interface
Parameters:
- MEM_TIMEOUT, 16: consecutive unready memory cycles tolerated before error; must be ≥2.
- WCNT_W, $clog2(MEM_TIMEOUT+1): wait counter width.

Ports:
- Clk  in  1  clock; all state updates on rising edge.
- Reset  in  1  synchronous, active-high reset.
- Rs1_d, Rs2_d  in  5  source registers of the instruction in D.
- Rs1_e, Rs2_e, Rd_e  in  5  sources/destination of the instruction in E.
- Rd_m, Rd_w  in  5  destinations in M and W.
- Reg_write_m, Reg_write_w  in  1  M/W instruction writes the register file.
- Load_e  in  1  instruction in E is a load.
- Pc_src_e  in  1  taken branch/jump resolved in E.
- Mem_req_m  in  1  instruction in M accesses data memory.
- Mem_ready  in  1  data memory completes the access this cycle.
- Stall_f, Stall_d, Stall_e, Stall_m  out  1  hold the PC and the F/D, D/E and E/M registers.
- Flush_d, Flush_e, Flush_w  out  1  Clear the F/D, D/E and M/W registers.
- Forward_a_e, Forward_b_e  out  2  ALU operand select: 00 register file, 01 W result, 10 M ALU result.
- Mem_err  out  1  sticky memory-timeout error.
- Stall_cycles, Flush_events  out  32  performance counters; see Configuration.

## Operation
- Forwarding, combinational, same rule for B using Rs2_e:
  - Forward_a_e = 10 if Reg_write_m && Rd_m≠0 && Rd_m==Rs1_e.
  - Otherwise 01 if Reg_write_w && Rd_w≠0 && Rd_w==Rs1_e.
  - Otherwise 00. M takes priority over W.
- Lw_stall = Load_e && Rd_e≠0 && (Rd_e==Rs1_d || Rd_e==Rs2_d).
- Mem_stall = Mem_req_m && !Mem_ready.
- FSM states:
  - RUN: Wait_cnt=0.
  - MWAIT: memory pending.
  - ERR: terminal until Reset.
- Transitions:
  - RUN → MWAIT on Mem_stall.
  - MWAIT → RUN on !Mem_stall.
  - In RUN or MWAIT, Mem_stall && Wait_cnt==MEM_TIMEOUT-1 → ERR.
  - Wait_cnt increments on every Mem_stall cycle and clears whenever Mem_stall is low.
- Output priority, highest first:
  1. Reset: Flush_d=Flush_e=Flush_w=1, all stalls 0.
  2. ERR: Stall_f/d/e/m=1, Flush_w=1, Flush_d=Flush_e=0.
  3. Mem_stall: same outputs as ERR. Branch and load-use actions are suppressed; the instructions causing them are frozen in D/E and re-evaluated on release.
  4. Pc_src_e: Flush_d=Flush_e=1, Stall_f=Stall_d=0.
  5. Lw_stall: Stall_f=Stall_d=1, Flush_e=1.
  6. Otherwise all controls are 0.
- Load_e and Pc_src_e are never both legitimately set. If they are, branch handling wins.
- Mem_err=1 exactly while in ERR.

## Timing
- Stall, flush and forward outputs are combinational from the current inputs and FSM state; zero-cycle latency.
- Reset values, state and outputs: state RUN, Wait_cnt 0, Mem_err 0, counters 0. Forward selects 00, stalls 0, flushes 1 (combinational override while Reset is high).
- Zero-wait memory (Mem_ready in the request cycle) causes no stall and no state change.
- Mem_ready arriving in MWAIT releases all stalls in that same cycle; the FSM is back in RUN on the next edge.
- With Mem_ready held low, the pipeline stalls for MEM_TIMEOUT cycles and Mem_err rises on the following edge.
- Reset asserted in MWAIT or ERR returns to RUN on the next edge.

## Configuration
- HAZARD_PERF_CNT_EN defined:
  - Stall_cycles increments on every non-reset cycle with Stall_f=1.
  - Flush_events increments on every non-reset cycle where Pc_src_e causes a flush.
  - Both are 32-bit and wrap 0xFFFFFFFF→0.
- HAZARD_PERF_CNT_EN undefined: the counters are not built and both ports are tied to 0.

## Test plan
- Forwarding: Rd_m=5, Reg_write_m=1 and Rd_w=5, Reg_write_w=1, Rs1_e=5 → Forward_a_e=10. Same with Rd_m=0 → Forward_a_e=01.
- Load-use: Load_e=1, Rd_e=7, Rs2_d=7 → Stall_f=Stall_d=Flush_e=1 for one cycle. Same with Rd_e=0 → no stall.
- Branch: Pc_src_e=1 → Flush_d=Flush_e=1, stalls 0. Flush_events goes 0→1 when the macro is defined.
- Memory wait: Mem_req_m=1 with Mem_ready low for 3 cycles, then high → Stall_f..m=1 and Flush_w=1 for 3 cycles; outputs clear in the ready cycle. Stall_cycles=3 with the macro.
- Timeout: MEM_TIMEOUT=4, Mem_ready held low → 4 stall cycles, then Mem_err=1 and stalls held. Reset for one cycle → Mem_err=0, state RUN.
- Branch during memory wait: Pc_src_e=1 while Mem_stall → no Flush_d/Flush_e until Mem_ready, then Flush_d=Flush_e=1 in the release cycle.
